// File: rtl/operand_fwd_mux_pkg.sv
// Shared definitions for the operand-forwarding selector.
//   SEL_RF     : select code meaning "register file, nothing forwarded"
//   sel_width  : width of the select code for a given producer count
//   idx_width  : width of a producer index for a given producer count
//   fwd_sel_t  : select-code type for the default three-producer build
package fwd_pkg;

   localparam int SEL_RF      = 0;
   localparam int DEF_NUM_SRC = 3;

   function automatic int sel_width(input int num_src);
      return $clog2(num_src + 1);
   endfunction

   function automatic int idx_width(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

   typedef logic [sel_width(DEF_NUM_SRC)-1:0] fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux_if.sv
// Bus bundle between the ID stage and one operand_fwd_mux instance.
//   master : ID-stage side, drives operand request and producer state
//   slave  : operand_fwd_mux side, returns hazard and registered operand
interface operand_fwd_mux_if
   import fwd_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 3,
   parameter int ADDR_W  = 5,
   parameter int SEL_W   = sel_width(NUM_SRC)
);
   logic [ADDR_W-1:0]         rs_addr;
   logic [WIDTH-1:0]          rf_data;
   logic                      in_valid;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*ADDR_W-1:0] src_rd;
   logic [NUM_SRC*WIDTH-1:0]  src_data;
   logic                      stall;
   logic                      flush;
   logic                      hazard;
   logic                      out_valid;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_sel;

   modport master (
      output rs_addr, rf_data, in_valid, src_valid, src_ready, src_rd, src_data,
             stall, flush,
      input  hazard, out_valid, out_data, out_sel
   );

   modport slave (
      input  rs_addr, rf_data, in_valid, src_valid, src_ready, src_rd, src_data,
             stall, flush,
      output hazard, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/operand_fwd_mux_prio_enc.sv
// Priority encoder over the producer match vector.
//   match     : one bit per producer, index 0 = youngest
//   any_match : at least one producer matches
//   win_idx   : lowest matching index (0 when nothing matches)
module fwd_prio_enc
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] match,
   output logic               any_match,
   output logic [IDX_W-1:0]   win_idx
);

   // Scan oldest to youngest so the youngest match overwrites last.
   always_comb begin
      any_match = |match;
      win_idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (match[i]) win_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/operand_fwd_mux.sv
// Registered operand-forwarding selector, one instance per source operand at
// the ID/EX boundary. Picks the youngest in-flight producer writing rs_addr,
// otherwise register-file data, flags a load-use hazard when that producer's
// result is not ready, and registers the operand under stall/flush control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand_fwd_mux_if.slave (request, producers, stall/flush,
//                hazard, out_valid/out_data/out_sel)
//   fwd_count  : saturating forwarded-operand count, only when
//                OPERAND_FWD_STATS_EN is defined
module operand_fwd_mux
   import fwd_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int NUM_SRC = 3,
   parameter  int ADDR_W  = 5,
   localparam int SEL_W   = sel_width(NUM_SRC),
   localparam int IDX_W   = idx_width(NUM_SRC)
) (
   input  logic              clk,
   input  logic              rst_n,
   operand_fwd_mux_if.slave  bus
`ifdef OPERAND_FWD_STATS_EN
   ,
   output logic [15:0]       fwd_count
`endif
);

   logic [NUM_SRC-1:0] match;
   logic               any_match;
   logic [IDX_W-1:0]   win_idx;
   logic [WIDTH-1:0]   sel_data;
   logic [SEL_W-1:0]   sel_code;
   logic               win_ready;
   logic               hazard;
   logic               load;

   logic               out_valid_q;
   logic [WIDTH-1:0]   out_data_q;
   logic [SEL_W-1:0]   out_sel_q;

   // x0 is hardwired zero: never forward it, whatever a producer claims.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         match[i] = bus.src_valid[i]
                  && (bus.src_rd[i*ADDR_W +: ADDR_W] == bus.rs_addr)
                  && (bus.rs_addr != '0);
      end
   end

   fwd_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_prio_enc (
      .match     (match),
      .any_match (any_match),
      .win_idx   (win_idx)
   );

   always_comb begin
      sel_data  = bus.rf_data;
      sel_code  = SEL_W'(SEL_RF);
      win_ready = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (any_match && (win_idx == IDX_W'(i))) begin
            sel_data  = bus.src_data[i*WIDTH +: WIDTH];
            sel_code  = SEL_W'(i + 1);
            win_ready = bus.src_ready[i];
         end
      end
   end

   // Only the winner's readiness matters; an older ready copy is stale.
   assign hazard     = bus.in_valid && any_match && !win_ready;
   assign bus.hazard = hazard;
   assign load       = !bus.flush && !bus.stall && !hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (bus.stall) begin
         out_valid_q <= out_valid_q;
      end else if (hazard) begin
         out_valid_q <= 1'b0;
         out_sel_q   <= SEL_W'(SEL_RF);
      end else begin
         out_valid_q <= bus.in_valid;
         out_data_q  <= sel_data;
         out_sel_q   <= sel_code;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

`ifdef OPERAND_FWD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_count <= '0;
      end else if (load && bus.in_valid && (sel_code != SEL_W'(SEL_RF))
                   && (fwd_count != 16'hFFFF)) begin
         fwd_count <= fwd_count + 16'd1;
      end
   end
`endif

endmodule
